// File: rtl/decoder_seq_pkg.sv
// Shared types and sizing for the sequenced select/enable decoder.
package decoder_seq_pkg;

    localparam int unsigned N = 5;
    localparam int unsigned W = 1 << N;

    // Request mode codes as presented on the mode input
    typedef enum logic [1:0] {
        MODE_ONEHOT = 2'b00,
        MODE_THERMO = 2'b01,
        MODE_SWEEP  = 2'b10,
        MODE_RSVD   = 2'b11
    } mode_e;

    // Sequencer states: HOLD has a single (final) beat pending, SWEEP has more to come
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_HOLD  = 2'd1,
        S_SWEEP = 2'd2
    } state_e;

endpackage

// File: rtl/decoder_seq_dec.sv
// Combinational N-to-2**N one-hot decoder.
module decoder_seq_dec #(
    parameter int unsigned N = 5
) (
    input  logic [N-1:0]      idx_i,
    output logic [(1<<N)-1:0] onehot_o
);

    localparam int unsigned W = 1 << N;

    assign onehot_o = W'(1) << idx_i;

endmodule

// File: rtl/decoder_seq.sv
// Registered, handshaked decoder: one-hot, thermometer and multi-beat one-hot sweep.
module decoder_seq
    import decoder_seq_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1:0]    mode,
    input  logic          enable,
    input  logic [N-1:0]  encoded,
    input  logic [N-1:0]  limit,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  decoded,
    output logic          out_last,
    output logic          busy
);

    state_e         state_q, state_d;
    logic [N-1:0]   p_q, p_d;
    logic [N-1:0]   limit_q, limit_d;
    logic           enable_q, enable_d;
    mode_e          mode_q, mode_d;
    logic [W-1:0]   decoded_q, decoded_d;
    logic           last_q, last_d;
    logic           valid_q, valid_d;

    logic           hs_c;
    logic           accept_c;
    logic [N-1:0]   p_inc_c;
    logic [N-1:0]   dec_idx_c;
    logic [W-1:0]   onehot_c;
    logic [W-1:0]   thermo_c;

    // Handshakes; a new request may land on the same edge as the final beat
    assign hs_c      = valid_q & out_ready;
    assign in_ready  = rst & ((state_q == S_IDLE) | (hs_c & last_q));
    assign accept_c  = in_valid & in_ready;
    assign p_inc_c   = p_q + N'(1);
    assign dec_idx_c = accept_c ? encoded : p_inc_c;

    // One shared one-hot decoder serves both the first beat and sweep advances
    decoder_seq_dec #(
        .N (N)
    ) u_dec (
        .idx_i    (dec_idx_c),
        .onehot_o (onehot_c)
    );

    // Thermometer word straight from the request index
    always_comb begin
        thermo_c = '0;
        for (int unsigned i = 0; i < W; i++) begin
            thermo_c[i] = (i <= 32'(encoded));
        end
    end

    // Next-state: capture on accept, advance sweep or retire on output handshake
    always_comb begin
        state_d   = state_q;
        p_d       = p_q;
        limit_d   = limit_q;
        enable_d  = enable_q;
        mode_d    = mode_q;
        decoded_d = decoded_q;
        last_d    = last_q;
        valid_d   = valid_q;

        if (accept_c) begin
            mode_d    = mode_e'(mode);
            enable_d  = enable;
            p_d       = encoded;
            limit_d   = limit;
            valid_d   = 1'b1;
            last_d    = 1'b1;
            state_d   = S_HOLD;
            decoded_d = '0;
            case (mode_e'(mode))
                MODE_ONEHOT: if (enable) decoded_d = onehot_c;
                MODE_THERMO: if (enable) decoded_d = thermo_c;
                MODE_SWEEP: begin
                    // Disabled sweep collapses to a single all-zero beat
                    if (enable) begin
                        decoded_d = onehot_c;
                        last_d    = (encoded == limit);
                        state_d   = (encoded == limit) ? S_HOLD : S_SWEEP;
                    end
                end
                default: ;
            endcase
        end else if (hs_c) begin
            if (last_q) begin
                state_d   = S_IDLE;
                valid_d   = 1'b0;
                decoded_d = '0;
                last_d    = 1'b0;
            end else if (state_q == S_SWEEP && mode_q == MODE_SWEEP) begin
                // Index wraps modulo 2**N; no saturation
                p_d       = p_inc_c;
                decoded_d = enable_q ? onehot_c : '0;
                last_d    = (p_inc_c == limit_q);
                state_d   = (p_inc_c == limit_q) ? S_HOLD : S_SWEEP;
            end
        end
    end

    // State and output registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            p_q       <= '0;
            limit_q   <= '0;
            enable_q  <= 1'b0;
            mode_q    <= MODE_ONEHOT;
            decoded_q <= '0;
            last_q    <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            p_q       <= p_d;
            limit_q   <= limit_d;
            enable_q  <= enable_d;
            mode_q    <= mode_d;
            decoded_q <= decoded_d;
            last_q    <= last_d;
            valid_q   <= valid_d;
        end
    end

    assign out_valid = valid_q;
    assign decoded   = decoded_q;
    assign out_last  = last_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_decoder_seq.sv
// Directed bench for decoder_seq with hand-computed expected words.
module tb_decoder_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  mode;
    logic        enable;
    logic [4:0]  encoded;
    logic [4:0]  limit;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] decoded;
    logic        out_last;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    decoder_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .enable    (enable),
        .encoded   (encoded),
        .limit     (limit),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .decoded   (decoded),
        .out_last  (out_last),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present a request at a falling edge and hold it until accepted
    task automatic req(input logic [1:0] m, input logic en, input logic [4:0] enc, input logic [4:0] lim);
        @(negedge clk);
        mode     = m;
        enable   = en;
        encoded  = enc;
        limit    = lim;
        in_valid = 1'b1;
        for (int i = 0; i < 100 && !in_ready; i++) @(negedge clk);
        check("req_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Observe the next output beat (out_ready assumed high)
    task automatic beat(input string tag, input logic [31:0] w, input logic l);
        @(negedge clk);
        for (int i = 0; i < 100 && !out_valid; i++) @(negedge clk);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_word"}, decoded, w);
        check({tag, "_last"}, 32'(out_last), 32'(l));
    endtask

    task automatic idle_chk(input string tag);
        @(negedge clk);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_ovalid"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        mode      = 2'b00;
        enable    = 1'b0;
        encoded   = '0;
        limit     = '0;
        out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ovalid", 32'(out_valid), 32'd0);
        check("rst_word", decoded, 32'd0);
        check("rst_last", 32'(out_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_iready", 32'(in_ready), 32'd0);
        rst = 1'b1;
        #1 check("post_rst_iready", 32'(in_ready), 32'd1);

        // One-hot, enabled and disabled
        req(2'b00, 1'b1, 5'd7, 5'd0);
        beat("oh7", 32'h0000_0080, 1'b1);
        idle_chk("oh7_done");
        req(2'b00, 1'b0, 5'd7, 5'd0);
        beat("oh7_dis", 32'h0, 1'b1);

        // Thermometer
        req(2'b01, 1'b1, 5'd4, 5'd0);
        beat("th4", 32'h0000_001F, 1'b1);
        req(2'b01, 1'b1, 5'd31, 5'd0);
        beat("th31", 32'hFFFF_FFFF, 1'b1);
        req(2'b01, 1'b1, 5'd0, 5'd0);
        beat("th0", 32'h0000_0001, 1'b1);
        idle_chk("th_done");

        // Reserved mode and disabled sweep: single zero beat
        req(2'b11, 1'b1, 5'd5, 5'd9);
        beat("rsvd", 32'h0, 1'b1);
        idle_chk("rsvd_done");
        req(2'b10, 1'b0, 5'd4, 5'd10);
        beat("sw_dis", 32'h0, 1'b1);
        idle_chk("sw_dis_done");

        // Wrapping sweep 30 -> 1
        req(2'b10, 1'b1, 5'd30, 5'd1);
        beat("sw_b0", 32'h4000_0000, 1'b0);
        beat("sw_b1", 32'h8000_0000, 1'b0);
        beat("sw_b2", 32'h0000_0001, 1'b0);
        beat("sw_b3", 32'h0000_0002, 1'b1);
        idle_chk("sw_done");

        // Single-beat and full-length sweeps
        req(2'b10, 1'b1, 5'd3, 5'd3);
        beat("sw33", 32'h0000_0008, 1'b1);
        req(2'b10, 1'b1, 5'd3, 5'd2);
        for (int k = 0; k < 32; k++) begin
            logic [31:0] w;
            w = 32'h1 << ((3 + k) % 32);
            beat($sformatf("full_%0d", k), w, (k == 31));
        end
        idle_chk("full_done");

        // Backpressure mid-sweep, then back-to-back request on the last beat
        req(2'b10, 1'b1, 5'd0, 5'd7);
        beat("bp_b0", 32'h1, 1'b0);
        beat("bp_b1", 32'h2, 1'b0);
        beat("bp_b2", 32'h4, 1'b0);
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("stall_word", decoded, 32'h4);
            check("stall_last", 32'(out_last), 32'd0);
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_iready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        for (int k = 3; k < 7; k++) beat("bp_mid", 32'h1 << k, 1'b0);
        @(negedge clk);
        check("bp_last_word", decoded, 32'h80);
        check("bp_last_last", 32'(out_last), 32'd1);
        mode     = 2'b00;
        enable   = 1'b1;
        encoded  = 5'd9;
        limit    = 5'd0;
        in_valid = 1'b1;
        check("b2b_iready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("b2b_valid", 32'(out_valid), 32'd1);
        check("b2b_word", decoded, 32'h0000_0200);
        check("b2b_last", 32'(out_last), 32'd1);
        idle_chk("b2b_done");

        // Reset during beat 3 of a sweep
        req(2'b10, 1'b1, 5'd0, 5'd15);
        beat("rs_b0", 32'h1, 1'b0);
        beat("rs_b1", 32'h2, 1'b0);
        beat("rs_b2", 32'h4, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_word", decoded, 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_iready", 32'(in_ready), 32'd0);
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("after_rst_valid", 32'(out_valid), 32'd0);
        end
        req(2'b00, 1'b1, 5'd0, 5'd0);
        beat("rs_oh0", 32'h1, 1'b1);
        idle_chk("rs_done");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
